alu_arb: RTL

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_if.sv | 49 ++++
 rtl/alu_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_arb_if.sv
// Requester, result and shared-ALU signals of the alu_arb block.
// master = requesters plus the ALU (environment side), slave = the arbiter.
interface alu_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_src0;
    logic [31:0] req0_src1;
    logic [12:0] req0_aluop;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_src0;
    logic [31:0] req1_src1;
    logic [12:0] req1_aluop;

    logic        res0_valid;
    logic        res0_ready;
    logic [31:0] res0_data;
    logic        res0_ov;
    logic        res1_valid;
    logic        res1_ready;
    logic [31:0] res1_data;
    logic        res1_ov;

    logic [31:0] alu_src0;
    logic [31:0] alu_src1;
    logic [12:0] alu_op;
    logic [31:0] alu_res;
    logic        alu_ov;

    modport master (
        output req0_valid, req0_src0, req0_src1, req0_aluop,
        output req1_valid, req1_src0, req1_src1, req1_aluop,
        input  req0_ready, req1_ready,
        input  res0_valid, res0_data, res0_ov, res1_valid, res1_data, res1_ov,
        output res0_ready, res1_ready,
        input  alu_src0, alu_src1, alu_op,
        output alu_res, alu_ov
    );

    modport slave (
        input  req0_valid, req0_src0, req0_src1, req0_aluop,
        input  req1_valid, req1_src0, req1_src1, req1_aluop,
        output req0_ready, req1_ready,
        output res0_valid, res0_data, res0_ov, res1_valid, res1_data, res1_ov,
        input  res0_ready, res1_ready,
        output alu_src0, alu_src1, alu_op,
        input  alu_res, alu_ov
    );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU with a one-deep result
// slot per port. Define ALU_ARB_FIXED_PRIO_EN to make port 0 always win instead of round-robin.

module alu_arb_res (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        res_ready,
    input  logic        gnt,
    input  logic [31:0] alu_res,
    input  logic        alu_ov,
    output logic        elig,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_ov
);
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        ov_q, ov_d;

    // The slot can take a new op if it is empty or is being drained this cycle.
    assign elig = req_valid & (~valid_q | res_ready);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ov_d    = ov_q;
        if (gnt) begin
            valid_d = 1'b1;
            data_d  = alu_res;
            ov_d    = alu_ov;
        end else if (valid_q && res_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ov_q    <= ov_d;
        end
    end

    assign res_valid = valid_q;
    assign res_data  = data_q;
    assign res_ov    = ov_q;
endmodule

module alu_arb (
    input  logic        clk,
    input  logic        rst,
    alu_arb_if.slave    bus,
    output logic [15:0] grant_cnt
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic [31:0] src0;
        logic [31:0] src1;
        logic [12:0] aluop;
    } alu_req_t;

    typedef struct packed {
        logic        ov;
        logic [31:0] data;
    } alu_rsp_t;

    alu_req_t [NUM_PORTS-1:0] req;
    alu_rsp_t [NUM_PORTS-1:0] rsp;
    logic     [NUM_PORTS-1:0] req_valid;
    logic     [NUM_PORTS-1:0] res_ready;
    logic     [NUM_PORTS-1:0] res_valid;
    logic     [NUM_PORTS-1:0] elig;
    logic     [NUM_PORTS-1:0] gnt;
    alu_req_t                 alu_sel;
    logic     [15:0]          grant_cnt_q, grant_cnt_d;

    assign req[0]       = '{src0: bus.req0_src0, src1: bus.req0_src1, aluop: bus.req0_aluop};
    assign req[1]       = '{src0: bus.req1_src0, src1: bus.req1_src1, aluop: bus.req1_aluop};
    assign req_valid    = {bus.req1_valid, bus.req0_valid};
    assign res_ready    = {bus.res1_ready, bus.res0_ready};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        alu_arb_res u_res (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[p]),
            .res_ready (res_ready[p]),
            .gnt       (gnt[p]),
            .alu_res   (bus.alu_res),
            .alu_ov    (bus.alu_ov),
            .elig      (elig[p]),
            .res_valid (res_valid[p]),
            .res_data  (rsp[p].data),
            .res_ov    (rsp[p].ov)
        );
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = '0;
        if (!rst) gnt = elig[0] ? 2'b01 : {elig[1], 1'b0};
    end
`else
    logic rr_ptr_q, rr_ptr_d;

    // rr_ptr names the port that wins a tie; it always moves to the port just passed over.
    always_comb begin
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        if (!rst) begin
            if (&elig) gnt = rr_ptr_q ? 2'b10 : 2'b01;
            else       gnt = elig;
        end
        if (gnt[0])      rr_ptr_d = 1'b1;
        else if (gnt[1]) rr_ptr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= 1'b0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        alu_sel = '0;
        if (gnt[0])      alu_sel = req[0];
        else if (gnt[1]) alu_sel = req[1];
    end

    assign grant_cnt_d = grant_cnt_q + {15'd0, |gnt};

    always_ff @(posedge clk) begin
        if (rst) grant_cnt_q <= '0;
        else     grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt      = grant_cnt_q;
    assign bus.alu_src0   = alu_sel.src0;
    assign bus.alu_src1   = alu_sel.src1;
    assign bus.alu_op     = alu_sel.aluop;
    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.res0_valid = res_valid[0];
    assign bus.res0_data  = rsp[0].data;
    assign bus.res0_ov    = rsp[0].ov;
    assign bus.res1_valid = res_valid[1];
    assign bus.res1_data  = rsp[1].data;
    assign bus.res1_ov    = rsp[1].ov;
endmodule
